// File: rtl/onehot_dispatch_pkg.sv
// Shared types and constants for the 5-channel one-hot dispatcher.
package onehot_dispatch_pkg;

  localparam int NUM_CH    = 5;
  localparam int IDX_W     = 3;
  localparam int ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_GAP
  } state_e;

  function automatic logic idx_valid(input logic [IDX_W-1:0] idx);
    return idx < IDX_W'(NUM_CH);
  endfunction

endpackage

// File: rtl/onehot_dispatch_5ch_fifo.sv
// Synchronous FIFO that holds channel indices waiting for dispatch.
module dispatch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/onehot_dispatch_5ch.sv
// Buffers channel indices and replays each as a timed one-hot pulse plus quiet gap.
// Optional saturating invalid-index counter enabled by ONEHOT_DISPATCH_ERR_CNT_EN.
module onehot_dispatch_5ch
  import onehot_dispatch_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PULSE_LEN = 1,
  parameter int GAP_LEN   = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IDX_W-1:0]     idx_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [NUM_CH-1:0]    hot_vector_o,
  output logic                 done_o,
  output logic                 busy_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam logic [7:0] PULSE_LAST = 8'(PULSE_LEN - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_LEN - 1);

  state_e            state_q;
  logic [NUM_CH-1:0] hot_q;
  logic              done_q;
  logic [7:0]        cnt_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic [IDX_W-1:0]  fifo_head;
  logic              accept;

  assign accept = valid_i && ready_o;

  dispatch_fifo #(
    .DEPTH (DEPTH),
    .W     (IDX_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept && idx_valid(idx_i)),
    .pop_i   (state_q == ST_IDLE),
    .data_i  (idx_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // One down-counter is shared by DRIVE and GAP since they never overlap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      hot_q   <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            hot_q   <= NUM_CH'(1) << fifo_head;
            done_q  <= (PULSE_LEN == 1);
            cnt_q   <= PULSE_LAST;
            state_q <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == '0) begin
            hot_q  <= '0;
            done_q <= 1'b0;
            if (GAP_LEN > 0) begin
              cnt_q   <= GAP_LAST;
              state_q <= ST_GAP;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q  <= cnt_q - 1'b1;
            done_q <= (cnt_q == 8'd1);
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) state_q <= ST_IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready_o      = !fifo_full;
  assign hot_vector_o = hot_q;
  assign done_o       = done_q;
  assign busy_o       = (state_q != ST_IDLE) || !fifo_empty;

`ifdef ONEHOT_DISPATCH_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (accept && !idx_valid(idx_i) && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: doc/onehot_dispatch_5ch.md
# onehot_dispatch_5ch

Turns a stream of 3-bit channel indices into timed one-hot pulses on a 5-bit vector. It is the inverse of the 5-input priority encoder used on the event-collection side. Upstream control logic pushes channel numbers through a valid/ready handshake, and a small FIFO buffers them. A three-state FSM then drives each channel's line high for a programmed pulse length, followed by a guaranteed quiet gap.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- PULSE_LEN, 1: cycles a line stays high per dispatch; ≥1, ≤255.
- GAP_LEN, 0: extra all-zero cycles after each pulse; 0..255.
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- idx_i  in  3  channel index to dispatch.
- valid_i  in  1  idx_i is valid this cycle.
- ready_o  out  1  FIFO can accept; equals !full, registered-state based (no same-cycle pop lookahead).
- hot_vector_o  out  5  one-hot pulse output, registered.
- done_o  out  1  one-cycle pulse in the last DRIVE cycle of each dispatch.
- busy_o  out  1  FSM not IDLE, or FIFO not empty.
- err_cnt_o  out  8  count of invalid indices (see Configuration).

## Operation
- Accept: valid_i && ready_o at a rising edge.
  - idx_i 0..4: written to the FIFO tail.
  - idx_i 5..7: the handshake completes, nothing is written, and the error event fires.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head, load hot_vector_o = 1<<head, load the pulse counter, and go to DRIVE. Otherwise hot_vector_o = 0.
  - DRIVE: hold hot_vector_o for PULSE_LEN cycles. In the last cycle assert done_o. On exit, clear hot_vector_o and go to GAP if GAP_LEN>0, else IDLE.
  - GAP: hot_vector_o = 0 for GAP_LEN cycles, then IDLE.
- hot_vector_o is always zero or exactly one-hot. It never holds two bits at once.
- At least one all-zero cycle (the IDLE cycle) always separates consecutive pulses. This holds even with GAP_LEN=0, so a downstream edge detector sees distinct events.
- FIFO ordering:
  - Strict FIFO; indices are dispatched in accept order. Duplicates are allowed and dispatched separately.
  - Push and pop in the same cycle: both occur and the count is unchanged.
  - When full, ready_o=0 even if a pop occurs that cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.
- Reset:
  - Reset values: FSM=IDLE, FIFO empty (pointers and count 0), hot_vector_o=0, done_o=0, busy_o=0, ready_o=1 in the cycle after rst_i is sampled high, err_cnt_o=0.
  - Reset mid-pulse truncates the pulse immediately; no done_o is produced.
  - Queued entries are discarded.
  - valid_i is ignored while rst_i=1.

## Timing
- Accept at edge E with FSM IDLE and FIFO empty:
  - entry visible in the FIFO after E;
  - pop at E+1;
  - hot_vector_o high from E+1 through E+PULSE_LEN.
- Latency: one cycle from accept to the line going high.
- done_o coincides with the final high cycle.
- Dispatch period per entry: PULSE_LEN + GAP_LEN + 1 cycles.
- Sustained throughput: one index per dispatch period. The FIFO absorbs bursts up to DEPTH.
- busy_o updates from registered state and is valid the cycle after any change.

## Configuration
- Macro: ONEHOT_DISPATCH_ERR_CNT_EN.
- Defined:
  - each accepted invalid index (5..7) increments err_cnt_o by 1;
  - the counter saturates at 255;
  - only rst_i clears it.
- Undefined:
  - err_cnt_o is tied to 8'd0 and no counter flops exist;
  - invalid indices are still dropped silently with the handshake completed.

## Structure
- Shared package onehot_dispatch_pkg:
  - FSM state enum (ST_IDLE, ST_DRIVE, ST_GAP);
  - NUM_CH=5, IDX_W=3, ERR_CNT_W=8 constants;
  - function idx_valid(idx) returning idx < NUM_CH.
- One sub-module is natural: dispatch_fifo, a parameterized synchronous FIFO with push/pop/full/empty/head.
- The FSM, pulse and gap counters, and error counter live in the top.

## Test plan
- **Reset then single index:** PULSE_LEN=1, GAP_LEN=0. Reset, then push idx 3 → hot_vector_o=5'b01000 for exactly one cycle, one cycle after accept, with done_o in the same cycle. busy_o then drops.
- **Burst to full:** DEPTH=4, PULSE_LEN=3, GAP_LEN=2. Push 0,1,2,3,4 back-to-back.
  - ready_o drops after 4 accepts; the 5th is held until a pop frees a slot.
  - Outputs: 00001, 00010, 00100, 01000, 10000, each 3 cycles high with 3 zero cycles between pulses.
- **Invalid index:** with the macro defined, push 5, 7, then 2 → err_cnt_o=2 and only 5'b00100 is pulsed. With the macro undefined, err_cnt_o stays 0.
- **Counter saturation:** with the macro defined, push 300 invalid indices → err_cnt_o=255 and holds.
- **Simultaneous push/pop and wrap:** stream 12 indices at a 50% valid duty through DEPTH=4 → all 12 are dispatched in order, no loss or duplication, and pointers wrap at least twice.
- **Reset mid-operation:** PULSE_LEN=5. Assert rst_i for one cycle on the 3rd pulse cycle with 2 entries queued.
  - Next cycle: hot_vector_o=0, no done_o, FIFO empty, ready_o=1, err_cnt_o=0.
  - No further pulses.
